uart_rx_fsm: RTL and testbench



---
 rtl/uart_rx_fsm.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 8N1 UART receiver with mid-bit sampling and frame-error detection
//
// Receives 8N1 frames (start bit, 8 data bits LSB first, stop bit, no parity)
// on the asynchronous rxd line. The line is synchronised, start edges are
// detected, and every bit is sampled near the middle of its period using a
// baud counter derived from CLK_FREQ/BAUD.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in bit/s (CLK_FREQ/BAUD must be at least 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rxd        serial input, idles high, asynchronous to clk
//   rx_data    last correctly received byte, held between frames
//   rx_done    one-cycle strobe, rx_data valid in the same cycle
//   frame_err  one-cycle strobe when the stop bit samples low

module uart_rx_fsm #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic          s1;
   logic          s2;
   logic          s3;
   logic          fall;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nx;
   logic [7:0]    sh;
   logic [7:0]    sh_nx;
   logic [7:0]    rx_data_nx;
   logic          rx_done_nx;
   logic          frame_err_nx;

   // Two-flop synchroniser plus one delay stage for edge detection. All
   // three reset to the idle (high) level so that reset release on an idle
   // line never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rxd;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall = s3 & ~s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         sh        <= 8'h00;
         rx_data   <= 8'h00;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_idx   <= bit_idx_nx;
         sh        <= sh_nx;
         rx_data   <= rx_data_nx;
         rx_done   <= rx_done_nx;
         frame_err <= frame_err_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      bit_idx_nx   = bit_idx;
      sh_nx        = sh;
      rx_data_nx   = rx_data;
      rx_done_nx   = 1'b0;
      frame_err_nx = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            // Waiting on an edge rather than a low level means a line held
            // low after a break cannot retrigger reception.
            if (fall) begin
               state_nx = START;
            end
         end

         START: begin
            cnt_nx = cnt + CNT_ONE;
            // Half a bit in: re-check the line to reject short glitches.
            if (cnt == CNT_HALF) begin
               cnt_nx = '0;
               if (!s2) begin
                  state_nx   = DATA;
                  bit_idx_nx = 3'd0;
               end else begin
                  state_nx = IDLE;
               end
            end
         end

         DATA: begin
            cnt_nx = cnt + CNT_ONE;
            // Counting a full period from mid-start lands on mid-bit.
            if (cnt == CNT_FULL) begin
               cnt_nx          = '0;
               sh_nx[bit_idx]  = s2;
               bit_idx_nx      = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nx = STOP;
               end
            end
         end

         STOP: begin
            cnt_nx = cnt + CNT_ONE;
            // Returning to IDLE at mid-stop-bit leaves half a bit of margin
            // to catch a back-to-back start edge.
            if (cnt == CNT_FULL) begin
               cnt_nx   = '0;
               state_nx = IDLE;
               if (s2) begin
                  rx_data_nx = sh;
                  rx_done_nx = 1'b1;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end
         end

         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm with a strobe scoreboard

module tb_uart_rx_fsm;

   localparam int DIV     = 50_000_000 / 115200;
   localparam int HALF    = DIV / 2;
   localparam int LATENCY = 2 + HALF + 9 * DIV;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;

   int         checks   = 0;
   int         failures = 0;
   longint     cyc      = 0;
   logic [7:0] last_good;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      longint     at_cyc;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      logic [7:0] data;
      int         period;
      logic       stop_bit;
      int         idle_after;
      logic       exp_done;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   uart_rx_fsm #(
      .CLK_FREQ(50_000_000),
      .BAUD    (115200)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(1_000_000 * 10);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest expectation in
   // kind, data and cycle.
   always @(negedge clk) begin
      if (!rst && (rx_done || frame_err)) begin
         exp_t e;
         chk("strobe_exclusive", {63'd0, rx_done & frame_err}, 64'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_strobe actual=done%0b_err%0b required=none at cyc %0d",
                     rx_done, frame_err, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_kind_err", {63'd0, frame_err}, {63'd0, e.is_err});
            chk("strobe_data", {56'd0, rx_data}, {56'd0, e.data});
            chk("strobe_cycle", cyc, e.at_cyc);
         end
      end
   end

   task automatic drive_bit(input logic v, input int n);
      rxd = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called #1 after a posedge; the next posedge is edge 0 of the frame.
   task automatic send_frame(input logic [7:0] d, input int period, input logic stop_bit,
                             input logic expect_strobe, input logic exp_err,
                             input logic [7:0] exp_data);
      exp_t e;
      if (expect_strobe) begin
         e.is_err = exp_err;
         e.data   = exp_data;
         e.at_cyc = cyc + 1 + LATENCY;
         exp_q.push_back(e);
      end
      drive_bit(1'b0, period);
      for (int b = 0; b < 8; b++) drive_bit(d[b], period);
      drive_bit(stop_bit, period);
   endtask

   initial begin
      // Single byte, back-to-back burst with no idle, then +/-4% baud skew.
      vecs[0] = '{8'hA5, DIV, 1'b1, 2 * DIV, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h00, DIV, 1'b1, 0,       1'b1, 1'b0, 8'h00};
      vecs[2] = '{8'hFF, DIV, 1'b1, 0,       1'b1, 1'b0, 8'hFF};
      vecs[3] = '{8'h55, DIV, 1'b1, 0,       1'b1, 1'b0, 8'h55};
      vecs[4] = '{8'h3C, DIV, 1'b1, 2 * DIV, 1'b1, 1'b0, 8'h3C};
      vecs[5] = '{8'hA5, 417, 1'b1, 2 * DIV, 1'b1, 1'b0, 8'hA5};
      vecs[6] = '{8'hA5, 451, 1'b1, 2 * DIV, 1'b1, 1'b0, 8'hA5};

      rst = 1'b1;
      rxd = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("reset_rx_data", {56'd0, rx_data}, 64'd0);
      chk("reset_rx_done", {63'd0, rx_done}, 64'd0);
      chk("reset_frame_err", {63'd0, frame_err}, 64'd0);
      rst = 1'b0;
      last_good = 8'h00;
      drive_bit(1'b1, 20);

      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].data, vecs[i].period, vecs[i].stop_bit,
                    vecs[i].exp_done | vecs[i].exp_err, vecs[i].exp_err, vecs[i].exp_data);
         if (vecs[i].exp_done) last_good = vecs[i].exp_data;
         if (vecs[i].idle_after > 0) drive_bit(1'b1, vecs[i].idle_after);
      end
      chk("rx_data_held_after_table", {56'd0, rx_data}, {56'd0, last_good});

      // Glitch shorter than half a bit must be rejected, then 8'h81 accepted.
      drive_bit(1'b0, 100);
      drive_bit(1'b1, 2 * DIV);
      chk("glitch_rx_data_unchanged", {56'd0, rx_data}, {56'd0, last_good});
      send_frame(8'h81, DIV, 1'b1, 1'b1, 1'b0, 8'h81);
      last_good = 8'h81;
      drive_bit(1'b1, DIV);

      // Framing error, long break, recovery, then 8'h12.
      send_frame(8'h7E, DIV, 1'b0, 1'b1, 1'b1, last_good);
      drive_bit(1'b0, 20 * DIV);
      chk("break_rx_data_held", {56'd0, rx_data}, {56'd0, last_good});
      drive_bit(1'b1, 2 * DIV);
      send_frame(8'h12, DIV, 1'b1, 1'b1, 1'b0, 8'h12);
      last_good = 8'h12;
      drive_bit(1'b1, DIV);

      // Reset in the middle of data bit 4 of 8'hC3.
      begin
         logic [7:0] c3;
         c3 = 8'hC3;
         drive_bit(1'b0, DIV);
         for (int b = 0; b < 4; b++) drive_bit(c3[b], DIV);
         drive_bit(c3[4], HALF);
      end
      rst = 1'b1;
      rxd = 1'b1;
      #1;
      chk("midreset_rx_data", {56'd0, rx_data}, 64'd0);
      chk("midreset_rx_done", {63'd0, rx_done}, 64'd0);
      chk("midreset_frame_err", {63'd0, frame_err}, 64'd0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      last_good = 8'h00;
      drive_bit(1'b1, 2 * DIV);
      chk("post_reset_rx_data", {56'd0, rx_data}, 64'd0);
      send_frame(8'h96, DIV, 1'b1, 1'b1, 1'b0, 8'h96);
      last_good = 8'h96;
      drive_bit(1'b1, 200);

      chk("final_rx_data", {56'd0, rx_data}, {56'd0, last_good});
      chk("pending_strobes", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
